// File: rtl/ramtest.sv
// ramtest: Wishbone classic master that writes a seeded address pattern across
// word addresses 0..LAST_ADR, then reads the range back and counts mismatches.
// Each bus transfer is bounded by a cycle timeout.
//
// Handshake: a transfer is presented with cyc=stb=1 and held stable until
// the rising edge that samples wb_ack_i high while stb is high. Ack is ignored
// whenever stb is low. After every completed transfer the bus stays idle for
// exactly one cycle.
module ramtest #(
  parameter logic [22:0] LAST_ADR = 23'h7FFFFF,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk2x_i,
  input  logic        reset_in,
  input  logic        ram_rdy_i,
  input  logic        start_i,
  input  logic [15:0] seed_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [22:0] wb_adr_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [22:0] err_adr_o,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_WR       = 3'd2,
    S_WR_GAP   = 3'd3,
    S_RD       = 3'd4,
    S_RD_GAP   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t      state;
  logic [22:0] address;
  logic [15:0] seed_q;
  logic        rd_phase;
  logic [15:0] tcnt;
  logic [15:0] pattern;
  logic        mismatch;
  logic        at_last;
  logic        acked;

  // Expected data for the current address, and read-compare/ack qualifiers.
  always_comb begin
    pattern  = address[15:0] ^ seed_q;
    mismatch = (wb_dat_i != pattern);
    at_last  = (address == LAST_ADR);
    acked    = wb_stb_o && wb_ack_i;
  end

  assign dbg_state = state;

  // Test sequencer: state, address walk, bus drive and result registers.
  always_ff @(posedge clk2x_i or negedge reset_in) begin
    if (!reset_in) begin
      state       <= S_IDLE;
      address     <= '0;
      seed_q      <= '0;
      rd_phase    <= 1'b0;
      tcnt        <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= 2'b00;
      wb_dat_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_count_o <= '0;
      err_adr_o   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            seed_q      <= seed_i;
            address     <= '0;
            rd_phase    <= 1'b0;
            err_count_o <= '0;
            err_adr_o   <= '0;
            timeout_o   <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            busy_o      <= 1'b1;
            state       <= S_WAIT_RDY;
          end
        end

        S_WAIT_RDY: begin
          // Memory bridge is still in its power-up delay until ram_rdy_i.
          if (ram_rdy_i) begin
            tcnt     <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_sel_o <= 2'b11;
            wb_adr_o <= address;
            wb_dat_o <= pattern;
            state    <= S_WR;
          end
        end

        S_WR_GAP, S_RD_GAP: begin
          // One idle cycle is over; launch the next transfer of this pass.
          tcnt     <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_sel_o <= 2'b11;
          wb_adr_o <= address;
          if (rd_phase) begin
            wb_we_o  <= 1'b0;
            wb_dat_o <= '0;
            state    <= S_RD;
          end else begin
            wb_we_o  <= 1'b1;
            wb_dat_o <= pattern;
            state    <= S_WR;
          end
        end

        S_WR, S_RD: begin
          if (acked) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 2'b00;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            if (state == S_WR) begin
              if (at_last) begin
                address  <= '0;
                rd_phase <= 1'b1;
              end else begin
                address <= address + 23'd1;
              end
              state <= S_WR_GAP;
            end else begin
              if (mismatch) begin
                if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
                if (err_count_o == 16'd0) err_adr_o <= address;
              end
              if (at_last) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= (err_count_o == 16'd0) && !mismatch && !timeout_o;
                state  <= S_DONE;
              end else begin
                address <= address + 23'd1;
                state   <= S_RD_GAP;
              end
            end
          end else if (tcnt == TO_LIMIT) begin
            // Slave never answered: abandon the transfer and report.
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 2'b00;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            timeout_o <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramtest.sv
// tb_ramtest: randomized bench for ramtest with LAST_ADR=3, TIMEOUT=8.
// A behavioural Wishbone memory answers the DUT; the scoreboard holds the
// expected transfer sequence and the expected end-of-test results.
module tb_ramtest;

  localparam int LAST = 3;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        ram_rdy_i;
  logic        start_i;
  logic [15:0] seed_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [22:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_count_o;
  logic [22:0] err_adr_o;
  logic [2:0]  dbg_state;

  ramtest #(.LAST_ADR(23'(LAST)), .TIMEOUT(TMO)) dut (
    .clk2x_i(clk), .reset_in(reset_in), .ram_rdy_i(ram_rdy_i),
    .start_i(start_i), .seed_i(seed_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o), .err_adr_o(err_adr_o), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model / scoreboard state ----------------
  logic [39:0] exp_q[$];          // {we, adr, dat_o} expected per transfer
  logic [15:0] mem [0:3];
  int          lat_max   = 0;
  int          cur_lat   = 0;
  int          wait_cnt  = 0;
  bit          never_ack = 0;
  bit          noise_en  = 0;
  logic [3:0]  corrupt_mask = '0;
  bit          corrupt_zero = 0;
  bit          acc_prev = 0, acc_more = 0, rise_due = 0;
  int          stb_cnt  = 0;

  // expected end-of-test results from the model
  int          m_errs;
  logic [22:0] m_first;
  bit          m_nack;

  // ---------------- slave + compare process ----------------
  always @(negedge clk) begin
    logic [1:0]  a;
    logic [39:0] e;
    if (!reset_in) begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
      acc_prev = 0;
      rise_due = 0;
    end else begin
      check("dat_idle",  96'(!wb_we_o && (wb_dat_o != 16'h0)), 96'(0));
      check("adr_idle",  96'(!wb_cyc_o && (wb_adr_o != 23'h0)), 96'(0));
      check("busy_done", 96'(busy_o && done_o), 96'(0));
      check("cyc_busy",  96'(wb_cyc_o && !busy_o), 96'(0));
      if (rise_due) begin
        check("gap_rise", 96'(wb_cyc_o), 96'(1));
        rise_due = 0;
      end
      if (acc_prev) begin
        check("gap_drop", 96'(wb_cyc_o), 96'(0));
        rise_due = acc_more;
        acc_prev = 0;
      end
      if (wb_stb_o) stb_cnt++;
      if (wb_stb_o && !never_ack) begin
        if (wait_cnt >= cur_lat) begin
          wb_ack_i = 1'b1;
          a = wb_adr_o[1:0];
          if (wb_we_o) mem[a] = wb_dat_o;
          else wb_dat_i = corrupt_mask[a] ? (corrupt_zero ? 16'h0000 : ~mem[a]) : mem[a];
          if (exp_q.size() == 0) begin
            check("xfer_extra", 96'(1), 96'(0));
          end else begin
            e = exp_q.pop_front();
            check("xfer", 96'({wb_we_o, wb_adr_o, wb_dat_o}), 96'(e));
          end
          check("xfer_sel", 96'(wb_sel_o), 96'(2'b11));
          acc_prev = 1;
          acc_more = (exp_q.size() != 0);
          wait_cnt = 0;
          cur_lat  = $urandom_range(0, lat_max);
        end else begin
          wb_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        wb_ack_i = (noise_en && !wb_stb_o) ? 1'($urandom_range(0, 1)) : 1'b0;
        wait_cnt = 0;
        wb_dat_i = 16'($urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [95:0] all_outs();
    return 96'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                busy_o, done_o, pass_o, timeout_o, err_count_o, err_adr_o});
  endfunction

  task automatic start_test(input logic [15:0] s, input int rdy_dly, input int lmax,
                            input logic [3:0] cmask, input bit czero, input bit nack);
    logic [15:0] pat, ret;
    exp_q.delete();
    lat_max = lmax; cur_lat = $urandom_range(0, lmax);
    corrupt_mask = cmask; corrupt_zero = czero; never_ack = nack; m_nack = nack;
    m_errs = 0; m_first = '0;
    for (int a = 0; a <= LAST; a++) exp_q.push_back({1'b1, 23'(a), 16'(a) ^ s});
    for (int a = 0; a <= LAST; a++) exp_q.push_back({1'b0, 23'(a), 16'h0000});
    for (int a = 0; a <= LAST; a++) begin
      pat = 16'(a) ^ s;
      ret = cmask[a] ? (czero ? 16'h0000 : ~pat) : pat;
      if (ret != pat) begin
        if (m_errs == 0) m_first = 23'(a);
        m_errs++;
      end
    end
    ram_rdy_i = (rdy_dly == 0);
    @(negedge clk);
    seed_i = s; start_i = 1'b1; stb_cnt = 0;
    @(negedge clk);
    start_i = 1'b0; seed_i = 16'($urandom);
    check("start_busy", 96'({busy_o, done_o}), 96'(2'b10));
    if (rdy_dly > 0) begin
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        check("rdy_hold_cyc", 96'(wb_cyc_o), 96'(0));
      end
      ram_rdy_i = 1'b1;
    end
  endtask

  task automatic finish_test(input bit poke);
    bit ok = 0;
    if (poke) begin
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
    end
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done_o) ok = 1;
    end
    check("done_wait", 96'(ok), 96'(1));
    check("end_busy", 96'(busy_o), 96'(0));
    check("end_timeout", 96'(timeout_o), 96'(m_nack));
    check("end_pass", 96'(pass_o), 96'(!m_nack && m_errs == 0));
    if (!m_nack) begin
      check("end_errcnt", 96'(err_count_o), 96'(m_errs));
      check("end_erradr", 96'(err_adr_o), 96'(m_first));
      check("end_queue", 96'(exp_q.size()), 96'(0));
    end
    repeat (3) @(negedge clk);
    check("done_hold", 96'({done_o, busy_o}), 96'(2'b10));
    exp_q.delete();
  endtask

  task automatic run_test(input logic [15:0] s, input int rdy_dly, input int lmax,
                          input logic [3:0] cmask, input bit czero, input bit nack,
                          input bit poke);
    start_test(s, rdy_dly, lmax, cmask, czero, nack);
    finish_test(poke);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] lit [0:3];

  initial begin
    bit found;
    lit[0] = 16'hA5A5; lit[1] = 16'hA5A4; lit[2] = 16'hA5A7; lit[3] = 16'hA5A6;
    reset_in = 1'b0; ram_rdy_i = 1'b0; start_i = 1'b0; seed_i = '0;
    wb_ack_i = 1'b0; wb_dat_i = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 96'(0));
    reset_in = 1'b1;
    @(negedge clk);

    // Ideal 1-cycle-ack memory with seed A5A5.
    run_test(16'hA5A5, 0, 0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) check("pattern_mem", 96'(mem[i]), 96'(lit[i]));
    check("ideal_errcnt", 96'(err_count_o), 96'(0));
    check("ideal_pass", 96'(pass_o), 96'(1));

    // Address 2 reads back as zero.
    run_test(16'hA5A5, 0, 0, 4'b0100, 1, 0, 0);
    check("corrupt_errcnt", 96'(err_count_o), 96'(1));
    check("corrupt_erradr", 96'(err_adr_o), 96'(2));
    check("corrupt_pass", 96'(pass_o), 96'(0));

    // Slave never acks.
    run_test(16'h1234, 0, 0, 4'b0000, 0, 1, 0);
    check("timeout_stb_cycles", 96'(stb_cnt), 96'(TMO + 1));
    check("timeout_flag", 96'({timeout_o, done_o, pass_o}), 96'(3'b110));
    never_ack = 0;

    // Bridge ready held off for 100 cycles after start.
    run_test(16'($urandom), 100, 0, 4'b0000, 0, 0, 0);

    // Reset pulsed during the read of address 1.
    start_test(16'h5A5A, 0, 1, 4'b0000, 0, 0);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (wb_stb_o && !wb_we_o && wb_adr_o == 23'd1) found = 1;
    end
    check("reset_rd1_seen", 96'(found), 96'(1));
    #1 reset_in = 1'b0;
    #1 check("reset_mid_outs", all_outs(), 96'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    run_test(16'($urandom), 0, 2, 4'b0000, 0, 0, 0);
    check("after_reset_pass", 96'(pass_o), 96'(1));

    // Randomized runs: seed, ready delay, ack latency, corruption, ack noise,
    // and a start pulse while busy.
    for (int r = 0; r < 12; r++) begin
      noise_en = 1'($urandom_range(0, 1));
      run_test(16'($urandom), $urandom_range(0, 5), $urandom_range(0, 3),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0,
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
